// File: rtl/cam_pwr_seq_pkg.sv
// rtl/cam_pwr_seq_pkg.sv - shared state encoding and default timing for the camera power sequencer
package cam_pwr_seq_pkg;

   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_PWDN   = 3'd1,
      S_RST    = 3'd2,
      S_SETTLE = 3'd3,
      S_DONE   = 3'd4
   } state_e;

   localparam int unsigned DEF_LOCK_STABLE_CYC = 1024;
   localparam int unsigned DEF_PWDN_CYC        = 27000;
   localparam int unsigned DEF_RST_CYC         = 27000;
   localparam int unsigned DEF_SETTLE_CYC      = 540000;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer bringing an asynchronous level into the clk domain
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/cam_pwr_seq.sv
// rtl/cam_pwr_seq.sv - camera power-up sequencer gated on a filtered PLL lock
// CAM_SEQ_LOCKLOSS_RESTART_EN: lock loss after completion reruns the whole sequence.
module cam_pwr_seq
   import cam_pwr_seq_pkg::*;
#(
   parameter int unsigned LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
   parameter int unsigned PWDN_CYC        = DEF_PWDN_CYC,
   parameter int unsigned RST_CYC         = DEF_RST_CYC,
   parameter int unsigned SETTLE_CYC      = DEF_SETTLE_CYC
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_lock,
   output logic       xclk_en,
   output logic       cam_pwdn,
   output logic       cam_rst_n,
   output logic       sccb_start,
   output logic       seq_done,
   output logic       lock_lost,
   output logic [2:0] state_o
);

   localparam int unsigned MAX_CYC = max3(PWDN_CYC, RST_CYC, SETTLE_CYC);
   localparam int          CNT_W   = $clog2(MAX_CYC) + 1;
   localparam int          LOCK_W  = $clog2(LOCK_STABLE_CYC) + 1;

   localparam logic [CNT_W-1:0] LD_PWDN   = CNT_W'(PWDN_CYC - 1);
   localparam logic [CNT_W-1:0] LD_RST    = CNT_W'(RST_CYC - 1);
   localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_CYC - 1);

   logic              lock_s;
   logic              lock_ok;
   logic [LOCK_W-1:0] lock_cnt_q;
   logic [LOCK_W-1:0] lock_cnt_d;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              xclk_en_q;
   logic              cam_pwdn_q;
   logic              cam_rst_n_q;
   logic              sccb_start_q;
   logic              seq_done_q;
   logic              lock_lost_q;

   sync_2ff u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d_i (pll_lock),
      .q_o (lock_s)
   );

   // Any low sample of lock_s restarts the stability window, which also
   // covers the filter clear on a lock-loss abort.
   assign lock_ok = (lock_cnt_q == LOCK_W'(LOCK_STABLE_CYC));

   always_comb begin
      lock_cnt_d = lock_cnt_q;
      if (!lock_s) begin
         lock_cnt_d = '0;
      end else if (!lock_ok) begin
         lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_cnt_q <= '0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_WAIT;
         cnt_q        <= '0;
         xclk_en_q    <= 1'b0;
         cam_pwdn_q   <= 1'b1;
         cam_rst_n_q  <= 1'b0;
         sccb_start_q <= 1'b0;
         seq_done_q   <= 1'b0;
         lock_lost_q  <= 1'b0;
      end else begin
         sccb_start_q <= 1'b0;
         unique case (state_q)
            S_WAIT: begin
               if (lock_ok) begin
                  state_q   <= S_PWDN;
                  cnt_q     <= LD_PWDN;
                  xclk_en_q <= 1'b1;
               end
            end
            S_PWDN, S_RST, S_SETTLE: begin
               if (!lock_s) begin
                  state_q     <= S_WAIT;
                  cnt_q       <= '0;
                  xclk_en_q   <= 1'b0;
                  cam_pwdn_q  <= 1'b1;
                  cam_rst_n_q <= 1'b0;
                  lock_lost_q <= 1'b1;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else if (state_q == S_PWDN) begin
                  state_q    <= S_RST;
                  cnt_q      <= LD_RST;
                  cam_pwdn_q <= 1'b0;
               end else if (state_q == S_RST) begin
                  state_q     <= S_SETTLE;
                  cnt_q       <= LD_SETTLE;
                  cam_rst_n_q <= 1'b1;
               end else begin
                  state_q      <= S_DONE;
                  sccb_start_q <= 1'b1;
                  seq_done_q   <= 1'b1;
               end
            end
            S_DONE: begin
               if (!lock_s) begin
                  lock_lost_q <= 1'b1;
`ifdef CAM_SEQ_LOCKLOSS_RESTART_EN
                  state_q     <= S_WAIT;
                  cnt_q       <= '0;
                  xclk_en_q   <= 1'b0;
                  cam_pwdn_q  <= 1'b1;
                  cam_rst_n_q <= 1'b0;
                  seq_done_q  <= 1'b0;
`else
                  state_q     <= S_DONE;
`endif
               end
            end
            default: begin
               state_q     <= S_WAIT;
               cnt_q       <= '0;
               xclk_en_q   <= 1'b0;
               cam_pwdn_q  <= 1'b1;
               cam_rst_n_q <= 1'b0;
               seq_done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign xclk_en    = xclk_en_q;
   assign cam_pwdn   = cam_pwdn_q;
   assign cam_rst_n  = cam_rst_n_q;
   assign sccb_start = sccb_start_q;
   assign seq_done   = seq_done_q;
   assign lock_lost  = lock_lost_q;
   assign state_o    = state_q;

endmodule
